// File: rtl/l2_bank_req_buffer.sv
// l2_bank_req_buffer
// Request buffer in front of one L2 SRAM bank. Granted requests are queued in a
// small FIFO and issued to the bank whenever it is ready. Each issued access is
// tracked through the one-cycle SRAM read latency, and a response (ID plus read
// data) is returned two cycles after issue, in request order.
module l2_bank_req_buffer #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 64,
   parameter int unsigned BE_WIDTH       = DATA_WIDTH / 8,
   parameter int unsigned ID_WIDTH       = 16,
   parameter int unsigned ADDR_MEM_WIDTH = 12,
   parameter int unsigned FIFO_DEPTH     = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   // request side
   input  logic                      data_req_i,
   input  logic [ADDR_WIDTH-1:0]     data_add_i,
   input  logic                      data_wen_i,
   input  logic [DATA_WIDTH-1:0]     data_wdata_i,
   input  logic [BE_WIDTH-1:0]       data_be_i,
   input  logic [ID_WIDTH-1:0]       data_ID_i,
   output logic                      data_gnt_o,
   // SRAM bank side
   input  logic                      mem_ready_i,
   output logic                      mem_cen_o,
   output logic                      mem_wen_o,
   output logic [ADDR_MEM_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0]     mem_wdata_o,
   output logic [BE_WIDTH-1:0]       mem_be_o,
   input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
   // response side
   output logic                      data_r_valid_o,
   output logic [ID_WIDTH-1:0]       data_r_ID_o,
   output logic [DATA_WIDTH-1:0]     data_r_rdata_o
);

   localparam int unsigned OFF_W = $clog2(BE_WIDTH);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   // One queued request; only the word-address bits are kept.
   typedef struct packed {
      logic [ADDR_MEM_WIDTH-1:0] addr;
      logic                      wen;
      logic [DATA_WIDTH-1:0]     wdata;
      logic [BE_WIDTH-1:0]       be;
      logic [ID_WIDTH-1:0]       id;
   } req_t;

   req_t             fifo_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;

   logic full;
   logic empty;
   logic push;
   logic pop;
   req_t push_entry;
   req_t head;

   // Response pipeline stage 1: access issued last cycle, SRAM data arriving now.
   logic                s1_valid_q;
   logic                s1_read_q;
   logic [ID_WIDTH-1:0] s1_id_q;

   // Byte-offset and upper address bits play no part in the bank access.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{data_add_i[ADDR_WIDTH-1:ADDR_MEM_WIDTH+OFF_W],
                               data_add_i[OFF_W-1:0]};

   // FIFO status, grant and handshake qualifiers.
   always_comb begin
      full       = (count_q == CNT_W'(FIFO_DEPTH));
      empty      = (count_q == '0);
      data_gnt_o = ~full;
      push       = data_req_i & ~full;
      pop        = ~empty & mem_ready_i;
   end

   // Pack the incoming request into a FIFO entry.
   always_comb begin
      push_entry       = '0;
      push_entry.addr  = data_add_i[ADDR_MEM_WIDTH+OFF_W-1:OFF_W];
      push_entry.wen   = data_wen_i;
      push_entry.wdata = data_wdata_i;
      push_entry.be    = data_be_i;
      push_entry.id    = data_ID_i;
   end

   // Head entry drives the bank directly; cen/wen only assert on an issue.
   always_comb begin
      head        = fifo_q[rd_ptr_q];
      mem_cen_o   = ~pop;
      mem_wen_o   = pop ? head.wen : 1'b1;
      mem_addr_o  = head.addr;
      mem_wdata_o = head.wdata;
      mem_be_o    = head.be;
   end

   // FIFO storage: payload only, validity is tracked by the count.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= push_entry;
      end
   end

   // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Stage 1: remember what was issued while the SRAM produces its data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_read_q  <= 1'b0;
         s1_id_q    <= '0;
      end else begin
         s1_valid_q <= pop;
         s1_read_q  <= pop & head.wen;
         if (pop) begin
            s1_id_q <= head.id;
         end
      end
   end

   // Stage 2: present the response; ID and read data hold between responses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r_valid_o <= 1'b0;
         data_r_ID_o    <= '0;
         data_r_rdata_o <= '0;
      end else begin
         data_r_valid_o <= s1_valid_q;
         if (s1_valid_q) begin
            data_r_ID_o <= s1_id_q;
         end
         if (s1_valid_q && s1_read_q) begin
            data_r_rdata_o <= mem_rdata_i;
         end
      end
   end

   // Occupancy can never exceed the FIFO depth.
   a_count_bound : assert property (@(posedge clk) disable iff (!rst_n)
      count_q <= CNT_W'(FIFO_DEPTH));

   // A pop is only ever taken from a non-empty FIFO.
   a_pop_not_empty : assert property (@(posedge clk) disable iff (!rst_n)
      !mem_cen_o |-> (count_q != '0));

endmodule
